// File: rtl/issue_dispatch.sv
// issue_dispatch: in-order dispatch FIFO between decode and the ALU
// reservation station, branch unit and load/store unit. The head entry is
// steered to exactly one port by a route code captured at push time.
module issue_dispatch #(
    parameter int DEPTH    = 4,
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int FU_SEL_W = 2,
    parameter int OP_SEL_W = 4,
    parameter int TID_W    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            dec_imm_i,
    input  logic [4:0]                 dec_rs1_i,
    input  logic [4:0]                 dec_rs2_i,
    input  logic [4:0]                 dec_rd_i,
    input  logic [ALU_OP_W-1:0]        dec_alu_op_i,
    input  logic [XLEN-1:0]            dec_pc_i,
    input  logic [TID_W-1:0]           dec_thread_id_i,
    input  logic [FU_SEL_W-1:0]        dec_fu_sel_i,
    input  logic [OP_SEL_W-1:0]        dec_op_sel_i,
    input  logic                       dec_issue_stall_i,
    output logic                       stall_o,
    output logic                       rs_valid_o,
    input  logic                       rs_ready_i,
    output logic                       br_valid_o,
    input  logic                       br_ready_i,
    output logic                       ls_valid_o,
    input  logic                       ls_ready_i,
    output logic [XLEN-1:0]            disp_imm_o,
    output logic [4:0]                 disp_rs1_o,
    output logic [4:0]                 disp_rs2_o,
    output logic [4:0]                 disp_rd_o,
    output logic [ALU_OP_W-1:0]        disp_alu_op_o,
    output logic [XLEN-1:0]            disp_pc_o,
    output logic [TID_W-1:0]           disp_thread_id_o,
    output logic [OP_SEL_W-1:0]        disp_op_sel_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [OP_SEL_W-1:0] OP_SEL_NONE   = OP_SEL_W'(0);
    localparam logic [FU_SEL_W-1:0] FU_SEL_NONE   = FU_SEL_W'(0);
    localparam logic [FU_SEL_W-1:0] FU_SEL_RS     = FU_SEL_W'(1);
    localparam logic [FU_SEL_W-1:0] FU_SEL_BRANCH = FU_SEL_W'(2);
    localparam logic [FU_SEL_W-1:0] FU_SEL_LOAD   = FU_SEL_W'(3);

    localparam logic [1:0] ROUTE_RS = 2'd0;
    localparam logic [1:0] ROUTE_BR = 2'd1;
    localparam logic [1:0] ROUTE_LS = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]     imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [ALU_OP_W-1:0] alu_op;
        logic [XLEN-1:0]     pc;
        logic [TID_W-1:0]    tid;
        logic [OP_SEL_W-1:0] op_sel;
        logic [1:0]          route;
    } entry_t;

    // Unknown selects fall back to the ALU reservation station.
    function automatic logic [1:0] route_of(input logic [FU_SEL_W-1:0] fu_sel);
        logic [1:0] route;
        case (fu_sel)
            FU_SEL_BRANCH: route = ROUTE_BR;
            FU_SEL_LOAD:   route = ROUTE_LS;
            FU_SEL_RS:     route = ROUTE_RS;
            FU_SEL_NONE:   route = ROUTE_RS;
            default:       route = ROUTE_RS;
        endcase
        return route;
    endfunction

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    entry_t           head_s;
    entry_t           wr_entry_s;
    logic             in_valid_s;
    logic             not_empty_s;
    logic             push_s;
    logic             pop_s;

    assign head_s      = mem_r[rd_ptr_r];
    assign not_empty_s = (count_r != CNT_W'(0));

    // Port valids and payload depend only on stored state, never on inputs.
    assign rs_valid_o       = not_empty_s && (head_s.route == ROUTE_RS);
    assign br_valid_o       = not_empty_s && (head_s.route == ROUTE_BR);
    assign ls_valid_o       = not_empty_s && (head_s.route == ROUTE_LS);
    assign disp_imm_o       = head_s.imm;
    assign disp_rs1_o       = head_s.rs1;
    assign disp_rs2_o       = head_s.rs2;
    assign disp_rd_o        = head_s.rd;
    assign disp_alu_op_o    = head_s.alu_op;
    assign disp_pc_o        = head_s.pc;
    assign disp_thread_id_o = head_s.tid;
    assign disp_op_sel_o    = head_s.op_sel;
    assign occupancy_o      = count_r;
    // One spare entry absorbs the instruction decode sends before it sees stall.
    assign stall_o          = (count_r >= CNT_W'(DEPTH-1));

    // Qualify the decode output, build the entry to write, and decide push/pop.
    always_comb begin
        wr_entry_s        = '0;
        in_valid_s        = (dec_op_sel_i != OP_SEL_NONE) && !dec_issue_stall_i;
        wr_entry_s.imm    = dec_imm_i;
        wr_entry_s.rs1    = dec_rs1_i;
        wr_entry_s.rs2    = dec_rs2_i;
        wr_entry_s.rd     = dec_rd_i;
        wr_entry_s.alu_op = dec_alu_op_i;
        wr_entry_s.pc     = dec_pc_i;
        wr_entry_s.tid    = dec_thread_id_i;
        wr_entry_s.op_sel = dec_op_sel_i;
        wr_entry_s.route  = route_of(dec_fu_sel_i);
        push_s = in_valid_s && (count_r != CNT_W'(DEPTH)) && !flush_i;
        pop_s  = !flush_i && ((rs_valid_o && rs_ready_i) ||
                              (br_valid_o && br_ready_i) ||
                              (ls_valid_o && ls_ready_i));
    end

    // Entry storage: cleared on reset so the payload is never X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // Pointers and occupancy; flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (flush_i) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    issue_dispatch_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid_s (in_valid_s),
        .count_r    (count_r),
        .rs_valid_o (rs_valid_o),
        .br_valid_o (br_valid_o),
        .ls_valid_o (ls_valid_o)
    );

endmodule

// Protocol checks for issue_dispatch: no push into a full buffer, one port valid.
module issue_dispatch_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             flush_i,
    input logic             in_valid_s,
    input logic [CNT_W-1:0] count_r,
    input logic             rs_valid_o,
    input logic             br_valid_o,
    input logic             ls_valid_o
);

    // A push while full is dropped by the datapath; flag it unless flush discards it.
    always @(posedge clk) begin
        if (rst && !flush_i && in_valid_s) begin
            assert (count_r != CNT_W'(DEPTH));
        end
    end

    // The head is offered to at most one execution port.
    always @(posedge clk) begin
        if (rst) begin
            assert ($onehot0({rs_valid_o, br_valid_o, ls_valid_o}));
        end
    end

endmodule

// File: tb/tb_issue_dispatch.sv
// Self-checking bench for issue_dispatch: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_issue_dispatch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i;
    logic [31:0] dec_imm_i;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic [3:0]  dec_alu_op_i;
    logic [31:0] dec_pc_i;
    logic [0:0]  dec_thread_id_i;
    logic [1:0]  dec_fu_sel_i;
    logic [3:0]  dec_op_sel_i;
    logic        dec_issue_stall_i;
    logic        stall_o;
    logic        rs_valid_o, rs_ready_i;
    logic        br_valid_o, br_ready_i;
    logic        ls_valid_o, ls_ready_i;
    logic [31:0] disp_imm_o;
    logic [4:0]  disp_rs1_o, disp_rs2_o, disp_rd_o;
    logic [3:0]  disp_alu_op_o;
    logic [31:0] disp_pc_o;
    logic [0:0]  disp_thread_id_o;
    logic [3:0]  disp_op_sel_o;
    logic [2:0]  occupancy_o;

    issue_dispatch dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .dec_imm_i         (dec_imm_i),
        .dec_rs1_i         (dec_rs1_i),
        .dec_rs2_i         (dec_rs2_i),
        .dec_rd_i          (dec_rd_i),
        .dec_alu_op_i      (dec_alu_op_i),
        .dec_pc_i          (dec_pc_i),
        .dec_thread_id_i   (dec_thread_id_i),
        .dec_fu_sel_i      (dec_fu_sel_i),
        .dec_op_sel_i      (dec_op_sel_i),
        .dec_issue_stall_i (dec_issue_stall_i),
        .stall_o           (stall_o),
        .rs_valid_o        (rs_valid_o),
        .rs_ready_i        (rs_ready_i),
        .br_valid_o        (br_valid_o),
        .br_ready_i        (br_ready_i),
        .ls_valid_o        (ls_valid_o),
        .ls_ready_i        (ls_ready_i),
        .disp_imm_o        (disp_imm_o),
        .disp_rs1_o        (disp_rs1_o),
        .disp_rs2_o        (disp_rs2_o),
        .disp_rd_o         (disp_rd_o),
        .disp_alu_op_o     (disp_alu_op_o),
        .disp_pc_o         (disp_pc_o),
        .disp_thread_id_o  (disp_thread_id_o),
        .disp_op_sel_o     (disp_op_sel_o),
        .occupancy_o       (occupancy_o)
    );

    always #5 clk = ~clk;

    // Functional-unit selects: 0 none, 1 ALU RS, 2 branch, 3 load/store.
    typedef struct {
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic [0:0]  tid;
        logic [1:0]  fu;
        logic [3:0]  op;
    } ent_t;

    ent_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   dec_stall_r = 1'b0;   // decode's registered copy of stall_o

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [1:0] fu, input logic [31:0] pc);
        dec_fu_sel_i      = fu;
        dec_pc_i          = pc;
        dec_imm_i         = $urandom;
        dec_rs1_i         = 5'($urandom);
        dec_rs2_i         = 5'($urandom);
        dec_rd_i          = 5'($urandom);
        dec_alu_op_i      = 4'($urandom);
        dec_thread_id_i   = 1'($urandom);
        dec_op_sel_i      = 4'($urandom_range(1, 15));
        dec_issue_stall_i = 1'b0;
    endtask

    // kind 0: all-zero bubble, kind 1: stall bubble carrying junk fields.
    task automatic drive_idle(input int kind);
        drive_op(2'($urandom), $urandom);
        if (kind == 0) begin
            dec_imm_i = 32'd0; dec_rs1_i = 5'd0; dec_rs2_i = 5'd0; dec_rd_i = 5'd0;
            dec_alu_op_i = 4'd0; dec_pc_i = 32'd0; dec_thread_id_i = 1'b0;
            dec_fu_sel_i = 2'd0; dec_op_sel_i = 4'd0;
        end else begin
            dec_issue_stall_i = 1'b1;
        end
    endtask

    task automatic check_outputs();
        int   sz = q.size();
        logic er = 1'b0, eb = 1'b0, el = 1'b0;
        if (sz > 0) begin
            case (q[0].fu)
                2'd2:    eb = 1'b1;
                2'd3:    el = 1'b1;
                default: er = 1'b1;
            endcase
        end
        chk("rs_valid", 32'(rs_valid_o), 32'(er));
        chk("br_valid", 32'(br_valid_o), 32'(eb));
        chk("ls_valid", 32'(ls_valid_o), 32'(el));
        chk("occupancy", 32'(occupancy_o), 32'(sz));
        chk("stall", 32'(stall_o), 32'(sz >= DEPTH - 1));
        if (sz > 0) begin
            chk("pc", disp_pc_o, q[0].pc);
            chk("imm", disp_imm_o, q[0].imm);
            chk("regs", 32'({disp_rs1_o, disp_rs2_o, disp_rd_o}), 32'({q[0].rs1, q[0].rs2, q[0].rd}));
            chk("alu_op", 32'(disp_alu_op_o), 32'(q[0].alu));
            chk("tid", 32'(disp_thread_id_o), 32'(q[0].tid));
            chk("op_sel", 32'(disp_op_sel_o), 32'(q[0].op));
        end
    endtask

    // Reference behaviour for the coming clock edge.
    task automatic model_step();
        int   sz  = q.size();
        bit   in_v;
        bit   pop = 1'b0;
        ent_t e;
        in_v = (dec_op_sel_i != 4'd0) && !dec_issue_stall_i;
        if (sz > 0) begin
            case (q[0].fu)
                2'd2:    pop = br_ready_i;
                2'd3:    pop = ls_ready_i;
                default: pop = rs_ready_i;
            endcase
        end
        dec_stall_r = (sz >= DEPTH - 1);
        if (flush_i) begin
            q.delete();
            dec_stall_r = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (in_v && sz < DEPTH) begin
                e.imm = dec_imm_i; e.pc = dec_pc_i; e.rs1 = dec_rs1_i; e.rs2 = dec_rs2_i;
                e.rd = dec_rd_i; e.alu = dec_alu_op_i; e.tid = dec_thread_id_i;
                e.fu = dec_fu_sel_i; e.op = dec_op_sel_i;
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer an op only when decode has not registered a stall.
    task automatic send(input logic [1:0] fu, input logic [31:0] pc);
        if (dec_stall_r) drive_idle(0);
        else drive_op(fu, pc);
        cycle();
    endtask

    task automatic set_ready(input logic r, input logic b, input logic l);
        rs_ready_i = r; br_ready_i = b; ls_ready_i = l;
    endtask

    // Assert reset between edges and check every output clears without a clock.
    task automatic reset_check();
        rst = 1'b0;
        #1;
        chk("rst_rs_valid", 32'(rs_valid_o), 32'd0);
        chk("rst_br_valid", 32'(br_valid_o), 32'd0);
        chk("rst_ls_valid", 32'(ls_valid_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_occupancy", 32'(occupancy_o), 32'd0);
        chk("rst_pc", disp_pc_o, 32'd0);
        chk("rst_imm", disp_imm_o, 32'd0);
        chk("rst_misc", 32'({disp_rs1_o, disp_rs2_o, disp_rd_o, disp_alu_op_o,
                             disp_thread_id_o, disp_op_sel_o}), 32'd0);
        q.delete();
        dec_stall_r = 1'b0;
        drive_idle(0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        flush_i = 1'b0;
        set_ready(1'b0, 1'b0, 1'b0);
        drive_idle(0);
        #2;
        reset_check();

        // Back-to-back ALU ops with the reservation station ready.
        set_ready(1'b1, 1'b0, 1'b0);
        send(2'd1, 32'h0);
        send(2'd1, 32'h4);
        send(2'd1, 32'h8);
        drive_idle(0);
        repeat (2) cycle();

        // Mixed branch / load / ALU stream, all ports ready.
        set_ready(1'b1, 1'b1, 1'b1);
        send(2'd2, 32'h10);
        send(2'd3, 32'h14);
        send(2'd1, 32'h18);
        drive_idle(0);
        repeat (2) cycle();

        // Fill until stall with the RS blocked, then drain.
        set_ready(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send(2'd1, 32'h100 + 32'(4 * i));
        set_ready(1'b1, 1'b1, 1'b1);
        drive_idle(0);
        repeat (6) cycle();

        // Bubbles interleaved with two real ops.
        drive_idle(1); cycle();
        drive_idle(0); cycle();
        send(2'd0, 32'h200);
        drive_idle(1); cycle();
        drive_idle(0); cycle();
        send(2'd3, 32'h204);
        drive_idle(1); cycle();
        drive_idle(0); repeat (2) cycle();

        // Full FIFO, then flush together with a valid input and ready.
        set_ready(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send(2'd1, 32'h300 + 32'(4 * i));
        set_ready(1'b1, 1'b1, 1'b1);
        flush_i = 1'b1;
        drive_op(2'd1, 32'h3f0);
        cycle();
        flush_i = 1'b0;
        drive_idle(0);
        repeat (2) cycle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            set_ready(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 3) != 0));
            flush_i = ($urandom_range(0, 39) == 0);
            if (!dec_stall_r && $urandom_range(0, 3) != 0) drive_op(2'($urandom), $urandom);
            else drive_idle(int'($urandom_range(0, 1)));
            cycle();
        end
        flush_i = 1'b0;

        // Mid-stream reset with two entries held.
        set_ready(1'b0, 1'b0, 1'b0);
        send(2'd1, 32'h400);
        send(2'd2, 32'h404);
        drive_idle(0);
        cycle();
        #2;
        reset_check();
        set_ready(1'b1, 1'b1, 1'b1);
        send(2'd3, 32'h500);
        drive_idle(0);
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
